register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register.
REQ-002 Parameter NREG, default 8: register count, legal range 2..256.
REQ-003 Derived constant AW = ceil(log2(NREG)), not overridable: address width.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 DR  input  AW  destination (write) register select.
REQ-007 LD  input  1  write enable for this cycle.
REQ-008 D  input  WIDTH  write data.
REQ-009 SA  input  AW  read port A register select.
REQ-010 SB  input  AW  read port B register select.
REQ-011 A  output  WIDTH  read port A data.
REQ-012 B  output  WIDTH  read port B data.
REQ-013 WE_VEC  output  NREG  one-hot decoded write strobe, combinational.
REQ-014 VALID  output  NREG  per-register written-since-reset flags, registered.
REQ-015 ERR  output  1  sticky out-of-range write flag, registered.

Function
REQ-016 WE_VEC SHALL equal (1 << DR) when LD=1 and DR < NREG, else all zeros; purely combinational.
REQ-017 On each rising CLK with WE_VEC[i]=1, register i SHALL load D; all other registers hold.
REQ-018 A SHALL equal register[SA] combinationally; SA >= NREG SHALL read 0. B likewise with SB.
REQ-019 Both read ports SHALL be independent; SA=SB is legal and returns identical data.
REQ-020 VALID[i] SHALL set on the edge where register i is written and stay set until reset.
REQ-021 LD=1 with DR >= NREG SHALL write nothing and set ERR on that edge; ERR clears only on reset.
REQ-022 Write latency: data written at edge N SHALL be visible on A/B after edge N (same cycle only under REQ-027).
REQ-023 LD=0 SHALL leave all state, including ERR, unchanged.
REQ-024 A write to a register already VALID SHALL overwrite it; VALID stays 1.

Reset
REQ-025 RST=1 SHALL immediately, without a clock, force every register to 0, VALID to all zeros and ERR to 0.
REQ-026 While RST=1, writes SHALL be ignored. WE_VEC still reflects DR/LD combinationally. A write coincident with RST deassertion SHALL NOT occur before the next rising edge.

Configuration
REQ-027 Macro REGISTER_BANK_BYPASS_EN defined: when LD=1, DR < NREG and SA=DR, A SHALL equal D in the same cycle; likewise B when SB=DR.
REQ-028 Macro undefined: no bypass; A/B show the stored value until after the write edge.
REQ-029 Bypass SHALL never forward on an out-of-range DR.

Structure
REQ-030 The shared package SHALL hold the default WIDTH/NREG constants and the AW derivation function.
REQ-031 The one-hot decoder SHALL be a sub-module, onehot_decoder (parameters NREG, AW; ports DR, LD, Y), reused for WE_VEC.
REQ-032 The register array, VALID bits and ERR SHALL live in register_bank; there SHALL be no other sub-modules.

Verification
REQ-033 Reset: RST pulse mid-cycle with registers nonzero -> A=B=0, VALID=0, ERR=0 before the next edge.
REQ-034 Write/read: DR=3, D=16'hBEEF, LD=1 for one edge; then SA=3, SB=0 -> A=16'hBEEF, B=0, VALID=8'h08, WE_VEC=8'h08 during the write cycle.
REQ-035 Full sweep: write reg i with value i*16'h1111 for i=0..7, then read all pairs -> exact values; VALID=8'hFF.
REQ-036 Out-of-range: NREG=6, DR=7, LD=1 -> WE_VEC=0, no register changes, ERR=1 and stays 1 until RST.
REQ-037 Same-cycle read of write target: DR=SA=2, D=16'h1234, old value 16'h0055 -> A=16'h1234 with BYPASS_EN defined, 16'h0055 without; both 16'h1234 after the edge.
REQ-038 LD=0 with DR=5, D=16'hFFFF -> WE_VEC=0, register 5 and VALID unchanged.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared constants and helpers for the register bank.
// Holds the default geometry and the address-width derivation used by
// register_bank and onehot_decoder.
package register_bank_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREG  = 8;

  // Smallest address width that can name every register (ceil(log2(n))).
  // Never returns less than one bit so single-bit selects stay legal.
  function automatic int calc_aw(input int n);
    int aw;
    aw = 0;
    while ((1 << aw) < n) aw++;
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// One-hot write-strobe decoder.
// Y has exactly one bit set when LD is high and DR names an existing
// register; an out-of-range DR or LD low gives all zeros.
module onehot_decoder
  import register_bank_pkg::*;
#(
  parameter int NREG = DEFAULT_NREG,
  parameter int AW   = calc_aw(DEFAULT_NREG)
) (
  input  logic [AW-1:0]   DR,
  input  logic            LD,
  output logic [NREG-1:0] Y
);

  // Compare DR against every legal index; indices >= NREG never match.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    Y = '0;
    for (int i = 0; i < NREG; i++) begin
      if (LD && (DR == AW'(i))) Y[i] = 1'b1;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register bank: NREG x WIDTH registers, one write port, two read ports.
// Tracks per-register written-since-reset flags (VALID) and a sticky
// out-of-range write flag (ERR).
// Optional feature: define REGISTER_BANK_BYPASS_EN to forward write data
// to a read port in the same cycle when it selects the write target.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREG  = DEFAULT_NREG,
  localparam int AW    = calc_aw(NREG)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    DR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    SA,
  input  logic [AW-1:0]    SB,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [NREG-1:0]  WE_VEC,
  output logic [NREG-1:0]  VALID,
  output logic             ERR
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  valid_q, valid_d;
  logic             err_q, err_d;
  logic [NREG-1:0]  we_vec;
  logic [WIDTH-1:0] stored_a, stored_b;

  onehot_decoder #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .DR (DR),
    .LD (LD),
    .Y  (we_vec)
  );

  assign WE_VEC = we_vec;
  assign VALID  = valid_q;
  assign ERR    = err_q;

  // Next state: strobed registers take D, VALID accumulates strobes, and a
  // load that produced no strobe (DR out of range) sets the sticky ERR.
  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q | we_vec;
    err_d   = err_q | (LD & ~(|we_vec));
    for (int i = 0; i < NREG; i++) begin
      if (we_vec[i]) regs_d[i] = D;
    end
  end

  // State registers with asynchronous clear of data, flags and ERR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the register array is real flops that must read zero right
      // after reset, so every entry is cleared here rather than left as RAM.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      regs_q  <= regs_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Read muxes; a select beyond the last register matches nothing and reads 0.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (SA == AW'(i)) stored_a = regs_q[i];
      if (SB == AW'(i)) stored_b = regs_q[i];
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  // Forward D only when a real strobe fires, so an out-of-range DR never
  // bypasses.
  logic wr_hit;
  assign wr_hit = |we_vec;
  assign A = (wr_hit && (SA == DR)) ? D : stored_a;
  assign B = (wr_hit && (SB == DR)) ? D : stored_b;
`else
  assign A = stored_a;
  assign B = stored_b;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank.
// Two instances share stimulus: the default 8-entry bank and a 6-entry
// bank whose address space has out-of-range codes 6 and 7.
module tb_register_bank;

`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK, RST, LD;
  logic [2:0]  DR, SA, SB;
  logic [15:0] D;
  logic [15:0] A, B, A6, B6;
  logic [7:0]  WE_VEC, VALID;
  logic [5:0]  WE6, VALID6;
  logic        ERR, ERR6;

  int n_checks = 0;
  int n_fail   = 0;

  register_bank dut (
    .CLK(CLK), .RST(RST), .DR(DR), .LD(LD), .D(D), .SA(SA), .SB(SB),
    .A(A), .B(B), .WE_VEC(WE_VEC), .VALID(VALID), .ERR(ERR)
  );

  register_bank #(.WIDTH(16), .NREG(6)) dut6 (
    .CLK(CLK), .RST(RST), .DR(DR), .LD(LD), .D(D), .SA(SA), .SB(SB),
    .A(A6), .B(B6), .WE_VEC(WE6), .VALID(VALID6), .ERR(ERR6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain arrays per instance, updated from the rules.
  logic [15:0] m_reg [2][8];
  logic [7:0]  m_valid [2];
  logic        m_err [2];
  int          m_nreg [2] = '{8, 6};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
      m_valid[k] = '0;
      m_err[k]   = 1'b0;
    end
  endfunction

  function automatic void model_write();
    for (int k = 0; k < 2; k++) begin
      if (LD) begin
        if (int'(DR) < m_nreg[k]) begin
          m_reg[k][DR]   = D;
          m_valid[k][DR] = 1'b1;
        end else begin
          m_err[k] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [7:0] exp_we(input int k);
    if (LD && int'(DR) < m_nreg[k]) return 8'(1 << DR);
    return 8'h00;
  endfunction

  function automatic logic [15:0] exp_read(input int k, input logic [2:0] sel);
    if (int'(sel) >= m_nreg[k]) return 16'h0;
    if (BYP && LD && int'(DR) < m_nreg[k] && sel == DR) return D;
    return m_reg[k][sel];
  endfunction

  task automatic check_comb();
    check("we8",  64'(WE_VEC), 64'(exp_we(0)));
    check("a8",   64'(A),      64'(exp_read(0, SA)));
    check("b8",   64'(B),      64'(exp_read(0, SB)));
    check("we6",  64'(WE6),    64'(exp_we(1)));
    check("a6",   64'(A6),     64'(exp_read(1, SA)));
    check("b6",   64'(B6),     64'(exp_read(1, SB)));
  endtask

  task automatic check_state();
    check("valid8", 64'(VALID),  64'(m_valid[0]));
    check("err8",   64'(ERR),    64'(m_err[0]));
    check("valid6", 64'(VALID6), 64'(m_valid[1]));
    check("err6",   64'(ERR6),   64'(m_err[1]));
  endtask

  // Drive one cycle's inputs away from the edge, then check combinational outputs.
  task automatic drive(input logic rst, input logic ld, input logic [2:0] dr,
                       input logic [15:0] d, input logic [2:0] sa, input logic [2:0] sb);
    @(negedge CLK);
    RST = rst; LD = ld; DR = dr; D = d; SA = sa; SB = sb;
    if (rst) model_reset();
    #1;
    check_comb();
  endtask

  // Let the rising edge happen, update the model, check registered state.
  task automatic clock_edge();
    @(posedge CLK);
    if (!RST) model_write();
    #1;
    check_state();
  endtask

  typedef struct {
    logic        ld;
    logic [2:0]  dr;
    logic [15:0] d;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [7:0]  we;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [2:0] dr, input logic [15:0] d,
                              input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] we,
                              input logic [15:0] a, input logic [15:0] b, input logic [7:0] valid);
    vec_t v;
    v.ld = ld; v.dr = dr; v.d = d; v.sa = sa; v.sb = sb;
    v.we = we; v.a = a; v.b = b; v.valid = valid;
    return v;
  endfunction

  initial begin
    logic [15:0] old_v;
    logic [15:0] val;

    // Directed table: a/b are the values before the edge, valid after it.
    vecs.push_back(mk(1, 3, 16'hBEEF, 3, 0, 8'h08, BYP ? 16'hBEEF : 16'h0000, 16'h0, 8'h08));
    vecs.push_back(mk(0, 0, 16'h0000, 3, 0, 8'h00, 16'hBEEF, 16'h0, 8'h08));
    for (int i = 0; i < 8; i++) begin
      val   = 16'(i * 16'h1111);
      old_v = (i == 3) ? 16'hBEEF : 16'h0000;
      vecs.push_back(mk(1, 3'(i), val, 3'(i), 3'(i), 8'(1 << i),
                        BYP ? val : old_v, BYP ? val : old_v,
                        8'h08 | 8'((1 << (i + 1)) - 1)));
    end
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(0, 0, 16'h0, 3'(i), 3'(7 - i), 8'h00,
                        16'(i * 16'h1111), 16'((7 - i) * 16'h1111), 8'hFF));
    end
    vecs.push_back(mk(0, 5, 16'hFFFF, 5, 5, 8'h00, 16'h5555, 16'h5555, 8'hFF));
    vecs.push_back(mk(0, 0, 16'h0000, 5, 2, 8'h00, 16'h5555, 16'h2222, 8'hFF));
    vecs.push_back(mk(1, 5, 16'h0ABC, 5, 4, 8'h20, BYP ? 16'h0ABC : 16'h5555, 16'h4444, 8'hFF));
    vecs.push_back(mk(0, 0, 16'h0000, 5, 5, 8'h00, 16'h0ABC, 16'h0ABC, 8'hFF));

    // Reset state.
    RST = 1'b1; LD = 1'b0; DR = '0; D = '0; SA = '0; SB = '0;
    model_reset();
    #2;
    check("rst_a", 64'(A), 64'h0);
    check("rst_b", 64'(B), 64'h0);
    check_state();

    // Table-driven vectors on the 8-entry bank.
    for (int n = 0; n < vecs.size(); n++) begin
      drive(1'b0, vecs[n].ld, vecs[n].dr, vecs[n].d, vecs[n].sa, vecs[n].sb);
      check($sformatf("tbl%0d_we", n), 64'(WE_VEC), 64'(vecs[n].we));
      check($sformatf("tbl%0d_a", n),  64'(A),      64'(vecs[n].a));
      check($sformatf("tbl%0d_b", n),  64'(B),      64'(vecs[n].b));
      clock_edge();
      check($sformatf("tbl%0d_valid", n), 64'(VALID), 64'(vecs[n].valid));
    end
    check("tbl_err8", 64'(ERR), 64'h0);

    // Mid-cycle reset pulse with nonzero contents: clears without a clock.
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd3);
    check("pre_rst_a", 64'(A), 64'h0ABC);
    #1 RST = 1'b1;
    model_reset();
    #1;
    check("async_rst_a", 64'(A), 64'h0);
    check("async_rst_b", 64'(B), 64'h0);
    check("async_rst_valid", 64'(VALID), 64'h0);
    check("async_rst_err6", 64'(ERR6), 64'h0);
    check("async_rst_valid6", 64'(VALID6), 64'h0);
    RST = 1'b0;
    #1;
    check("post_rst_a", 64'(A), 64'h0);
    clock_edge();

    // Write attempted while reset is held: strobe visible, nothing stored.
    drive(1'b1, 1'b1, 3'd2, 16'h1111, 3'd2, 3'd2);
    check("rst_we", 64'(WE_VEC), 64'h04);
    clock_edge();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd1);
    check("rst_nowrite_a", 64'(A), 64'h0);
    clock_edge();
    check("rst_nowrite_valid", 64'(VALID), 64'h0);

    // Out-of-range write on the 6-entry bank.
    drive(1'b0, 1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd0);
    check("oor_we6", 64'(WE6), 64'h0);
    clock_edge();
    check("oor_err6", 64'(ERR6), 64'h1);
    check("oor_valid6", 64'(VALID6), 64'h0);
    drive(1'b0, 1'b0, 3'd7, 16'h5A5A, 3'd0, 3'd1);
    clock_edge();
    check("oor_err6_hold_ld0", 64'(ERR6), 64'h1);
    drive(1'b0, 1'b1, 3'd1, 16'h0101, 3'd1, 3'd0);
    clock_edge();
    check("oor_err6_hold_wr", 64'(ERR6), 64'h1);
    check("oor_valid6_wr", 64'(VALID6), 64'h02);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd0);
    check("oor_read6", 64'(A6), 64'h0101);
    clock_edge();

    // Same-cycle read of the write target.
    drive(1'b0, 1'b1, 3'd2, 16'h0055, 3'd0, 3'd0);
    clock_edge();
    drive(1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, 3'd2);
    check("same_cyc_a", 64'(A), BYP ? 64'h1234 : 64'h0055);
    check("same_cyc_b", 64'(B), BYP ? 64'h1234 : 64'h0055);
    clock_edge();
    check("after_edge_a", 64'(A), 64'h1234);
    check("after_edge_b", 64'(B), 64'h1234);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
